// File: rtl/dogbattle_pkg.sv
// Shared definitions for the dog-battle turn controller.
// Holds the controller state type, move codes, per-move damage values,
// winner codes and small arithmetic helpers used during move resolution.
package dogbattle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN    = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    localparam logic [1:0] MOVE_PASS   = 2'b00;
    localparam logic [1:0] MOVE_BITE   = 2'b01;
    localparam logic [1:0] MOVE_POUNCE = 2'b10;
    localparam logic [1:0] MOVE_DEFEND = 2'b11;

    localparam logic [3:0] DMG_NONE   = 4'd0;
    localparam logic [3:0] DMG_BITE   = 4'd1;
    localparam logic [3:0] DMG_POUNCE = 4'd2;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Raw damage a move deals before any defend reduction.
    function automatic logic [3:0] move_damage(input logic [1:0] move);
        logic [3:0] dmg;
        case (move)
            MOVE_BITE:   dmg = DMG_BITE;
            MOVE_POUNCE: dmg = DMG_POUNCE;
            default:     dmg = DMG_NONE;
        endcase
        return dmg;
    endfunction

    // Hit-point subtraction that stops at zero.
    function automatic logic [3:0] hp_sub_sat(input logic [3:0] hp, input logic [3:0] dmg);
        logic [3:0] res;
        if (hp > dmg) begin
            res = hp - dmg;
        end else begin
            res = 4'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/dogbattle_timeout_ctr.sv
// Idle-cycle counter for the active player.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clear      : return the count to zero (takes priority over enable)
//   enable     : count one idle cycle
//   expired    : registered flag, high while the count sits at TIMEOUT-1,
//                i.e. the current idle cycle is the TIMEOUT-th one
module dogbattle_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count_r;
    logic       expired_r;
    logic [7:0] count_inc_s;

    assign count_inc_s = count_r + 8'd1;
    assign expired     = expired_r;

    // Count idle cycles; expired is precomputed from the next count so it is a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r   <= 8'd0;
            expired_r <= (LAST == 8'd0);
        end else if (clear) begin
            count_r   <= 8'd0;
            expired_r <= (LAST == 8'd0);
        end else if (enable) begin
            count_r   <= count_inc_s;
            expired_r <= (count_inc_s == LAST);
        end else begin
            count_r   <= count_r;
            expired_r <= expired_r;
        end
    end

endmodule

// File: rtl/dogbattle_turn_ctrl.sv
// Turn controller for a two-player dog battle.
// Players alternate offering moves (pass, bite, pounce, defend); the
// controller accepts only the active player's move, resolves damage one
// cycle later, and ends the battle when a dog reaches zero hit points.
// Ports:
//   clk, rst_n           : clock and synchronous active-low reset
//   ena                  : global enable, low freezes everything and masks ready
//   start                : begin a battle from IDLE or OVER
//   p1_valid/p1_move     : player 1 move offer
//   p2_valid/p2_move     : player 2 move offer
//   p1_ready/p2_ready    : move accepted this cycle when ready & valid
//   p1_hp/p2_hp          : hit points
//   turn                 : active player (0 = P1, 1 = P2)
//   winner               : 00 none, 01 P1, 10 P2
//   busy                 : battle in progress (TURN or RESOLVE)
module dogbattle_turn_ctrl
    import dogbattle_pkg::*;
#(
    parameter int unsigned HP_INIT = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       p1_valid,
    input  logic [1:0] p1_move,
    input  logic       p2_valid,
    input  logic [1:0] p2_move,
    output logic       p1_ready,
    output logic       p2_ready,
    output logic [3:0] p1_hp,
    output logic [3:0] p2_hp,
    output logic       turn,
    output logic [1:0] winner,
    output logic       busy
);

    localparam logic [3:0] HP_START = 4'(HP_INIT);

    state_t     state_r;
    logic       turn_r;
    logic [1:0] winner_r;
    logic [3:0] p1_hp_r;
    logic [3:0] p2_hp_r;
    logic       p1_def_r;
    logic       p2_def_r;
    logic [1:0] move_r;
    logic       p1_ready_r;
    logic       p2_ready_r;
    logic       busy_r;

    logic       in_turn_s;
    logic       accept_s;
    logic       expired_s;
    logic       ctr_clear_s;
    logic       ctr_enable_s;
    logic       opp_def_s;
    logic [3:0] opp_hp_s;
    logic [3:0] raw_dmg_s;
    logic [3:0] dmg_s;
    logic [3:0] new_hp_s;

    assign in_turn_s = (state_r == ST_TURN);
    // Only the active player's valid can produce an acceptance.
    assign accept_s  = ena && in_turn_s && (turn_r ? p2_valid : p1_valid);

    // The counter is held at zero outside TURN, so every TURN entry starts from zero.
    assign ctr_clear_s  = ena && !in_turn_s;
    assign ctr_enable_s = ena && in_turn_s && !accept_s && !expired_s;

    dogbattle_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (ctr_clear_s),
        .enable  (ctr_enable_s),
        .expired (expired_s)
    );

    // Damage resolution for the latched move against the opponent of the mover.
    always_comb begin
        opp_def_s = 1'b0;
        opp_hp_s  = 4'd0;
        raw_dmg_s = move_damage(move_r);
        dmg_s     = raw_dmg_s;
        if (turn_r) begin
            opp_def_s = p1_def_r;
            opp_hp_s  = p1_hp_r;
        end else begin
            opp_def_s = p2_def_r;
            opp_hp_s  = p2_hp_r;
        end
        if (opp_def_s && (raw_dmg_s != 4'd0)) begin
            dmg_s = raw_dmg_s - 4'd1;
        end else begin
            dmg_s = raw_dmg_s;
        end
        new_hp_s = hp_sub_sat(opp_hp_s, dmg_s);
    end

    // Battle FSM with all game state and registered ready/busy outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            turn_r     <= 1'b0;
            winner_r   <= WIN_NONE;
            p1_hp_r    <= HP_START;
            p2_hp_r    <= HP_START;
            p1_def_r   <= 1'b0;
            p2_def_r   <= 1'b0;
            move_r     <= MOVE_PASS;
            p1_ready_r <= 1'b0;
            p2_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else if (ena) begin
            case (state_r)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state_r    <= ST_TURN;
                        turn_r     <= 1'b0;
                        winner_r   <= WIN_NONE;
                        p1_hp_r    <= HP_START;
                        p2_hp_r    <= HP_START;
                        p1_def_r   <= 1'b0;
                        p2_def_r   <= 1'b0;
                        p1_ready_r <= 1'b1;
                        p2_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_TURN: begin
                    // A real move on the expiring cycle still wins over the forced pass.
                    if (accept_s) begin
                        move_r     <= turn_r ? p2_move : p1_move;
                        state_r    <= ST_RESOLVE;
                        p1_ready_r <= 1'b0;
                        p2_ready_r <= 1'b0;
                    end else if (expired_s) begin
                        move_r     <= MOVE_PASS;
                        state_r    <= ST_RESOLVE;
                        p1_ready_r <= 1'b0;
                        p2_ready_r <= 1'b0;
                    end
                end
                ST_RESOLVE: begin
                    // Opponent's defend is spent by this move; mover's flag tracks its own move.
                    if (turn_r) begin
                        p2_def_r <= (move_r == MOVE_DEFEND);
                        p1_def_r <= 1'b0;
                        p1_hp_r  <= new_hp_s;
                    end else begin
                        p1_def_r <= (move_r == MOVE_DEFEND);
                        p2_def_r <= 1'b0;
                        p2_hp_r  <= new_hp_s;
                    end
                    if (new_hp_s == 4'd0) begin
                        state_r    <= ST_OVER;
                        winner_r   <= turn_r ? WIN_P2 : WIN_P1;
                        p1_ready_r <= 1'b0;
                        p2_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end else begin
                        state_r    <= ST_TURN;
                        turn_r     <= !turn_r;
                        p1_ready_r <= turn_r;
                        p2_ready_r <= !turn_r;
                        busy_r     <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    p1_ready_r <= 1'b0;
                    p2_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign p1_ready = p1_ready_r && ena;
    assign p2_ready = p2_ready_r && ena;
    assign p1_hp    = p1_hp_r;
    assign p2_hp    = p2_hp_r;
    assign turn     = turn_r;
    assign winner   = winner_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_dogbattle_turn_ctrl.sv
// Bench for dogbattle_turn_ctrl: two instances (HP 8 / timeout 15 and
// HP 2 / timeout 3) share the same stimulus and are compared every cycle
// against a rule-level game model; directed literal checks pin the model.
module tb_dogbattle_turn_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic       p1_valid = 1'b0;
    logic [1:0] p1_move = 2'd0;
    logic       p2_valid = 1'b0;
    logic [1:0] p2_move = 2'd0;

    logic       d_p1_ready [2];
    logic       d_p2_ready [2];
    logic [3:0] d_p1_hp    [2];
    logic [3:0] d_p2_hp    [2];
    logic       d_turn     [2];
    logic [1:0] d_winner   [2];
    logic       d_busy     [2];

    int checks = 0;
    int errors = 0;

    // Model state: phase 0 idle, 1 waiting for move, 2 resolving, 3 over.
    int hp_init [2] = '{8, 2};
    int tmo     [2] = '{15, 3};
    int m_phase [2];
    int m_hp    [2][2];
    int m_def   [2][2];
    int m_tn    [2];
    int m_win   [2];
    int m_cnt   [2];
    int m_mv    [2];

    always #5 clk = ~clk;

    dogbattle_turn_ctrl #(.HP_INIT(8), .TIMEOUT(15)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .p1_valid(p1_valid), .p1_move(p1_move), .p2_valid(p2_valid), .p2_move(p2_move),
        .p1_ready(d_p1_ready[0]), .p2_ready(d_p2_ready[0]),
        .p1_hp(d_p1_hp[0]), .p2_hp(d_p2_hp[0]), .turn(d_turn[0]),
        .winner(d_winner[0]), .busy(d_busy[0])
    );

    dogbattle_turn_ctrl #(.HP_INIT(2), .TIMEOUT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .p1_valid(p1_valid), .p1_move(p1_move), .p2_valid(p2_valid), .p2_move(p2_move),
        .p1_ready(d_p1_ready[1]), .p2_ready(d_p2_ready[1]),
        .p1_hp(d_p1_hp[1]), .p2_hp(d_p2_hp[1]), .turn(d_turn[1]),
        .winner(d_winner[1]), .busy(d_busy[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_start(input int i);
        m_phase[i] = 1;
        m_hp[i][0] = hp_init[i];
        m_hp[i][1] = hp_init[i];
        m_def[i][0] = 0;
        m_def[i][1] = 0;
        m_tn[i] = 0;
        m_win[i] = 0;
        m_cnt[i] = 0;
    endtask

    // Advance the game rules by one clock edge using the inputs held before it.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                model_start(i);
                m_phase[i] = 0;
            end else if (ena) begin
                if (m_phase[i] == 0 || m_phase[i] == 3) begin
                    if (start) model_start(i);
                end else if (m_phase[i] == 1) begin
                    if ((m_tn[i] == 0) ? p1_valid : p2_valid) begin
                        m_mv[i] = (m_tn[i] == 0) ? int'(p1_move) : int'(p2_move);
                        m_phase[i] = 2;
                    end else begin
                        m_cnt[i]++;
                        if (m_cnt[i] >= tmo[i]) begin
                            m_mv[i] = 0;
                            m_phase[i] = 2;
                        end
                    end
                end else begin
                    int mover = m_tn[i];
                    int opp = 1 - mover;
                    int dmg = (m_mv[i] == 1) ? 1 : (m_mv[i] == 2) ? 2 : 0;
                    if (m_def[i][opp] != 0) begin
                        dmg = (dmg > 0) ? dmg - 1 : 0;
                        m_def[i][opp] = 0;
                    end
                    m_def[i][mover] = (m_mv[i] == 3) ? 1 : 0;
                    m_hp[i][opp] = (m_hp[i][opp] > dmg) ? m_hp[i][opp] - dmg : 0;
                    if (m_hp[i][opp] == 0) begin
                        m_phase[i] = 3;
                        m_win[i] = mover + 1;
                    end else begin
                        m_tn[i] = opp;
                        m_phase[i] = 1;
                        m_cnt[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic model_compare();
        for (int i = 0; i < 2; i++) begin
            string s = (i == 0) ? "a" : "b";
            chk({s, "_p1_ready"}, int'(d_p1_ready[i]), (ena && m_phase[i] == 1 && m_tn[i] == 0) ? 1 : 0);
            chk({s, "_p2_ready"}, int'(d_p2_ready[i]), (ena && m_phase[i] == 1 && m_tn[i] == 1) ? 1 : 0);
            chk({s, "_p1_hp"}, int'(d_p1_hp[i]), m_hp[i][0]);
            chk({s, "_p2_hp"}, int'(d_p2_hp[i]), m_hp[i][1]);
            chk({s, "_turn"}, int'(d_turn[i]), m_tn[i]);
            chk({s, "_winner"}, int'(d_winner[i]), m_win[i]);
            chk({s, "_busy"}, int'(d_busy[i]), (m_phase[i] == 1 || m_phase[i] == 2) ? 1 : 0);
        end
    endtask

    // One clock: update the model at the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_compare();
    endtask

    task automatic play(input int player, input int move);
        if (player == 1) begin
            p1_valid = 1'b1;
            p1_move = 2'(move);
        end else begin
            p2_valid = 1'b1;
            p2_move = 2'(move);
        end
        step();
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            model_start(i);
            m_phase[i] = 0;
            m_mv[i] = 0;
        end

        // Reset state
        step();
        step();
        chk("lit_reset_p1_hp", int'(d_p1_hp[0]), 8);
        chk("lit_reset_p2_hp", int'(d_p2_hp[0]), 8);
        chk("lit_reset_busy", int'(d_busy[0]), 0);
        chk("lit_reset_ready", int'(d_p1_ready[0]), 0);
        chk("lit_reset_winner", int'(d_winner[0]), 0);
        rst_n = 1'b1;
        step();

        // Start, then P1 pounce
        start = 1'b1;
        step();
        start = 1'b0;
        chk("lit_start_p1_ready", int'(d_p1_ready[0]), 1);
        chk("lit_start_busy", int'(d_busy[0]), 1);
        play(1, 2);
        chk("lit_pounce_p2_hp", int'(d_p2_hp[0]), 6);
        chk("lit_pounce_turn", int'(d_turn[0]), 1);
        chk("lit_pounce_p2_ready", int'(d_p2_ready[0]), 1);
        chk("lit_b_kill_p2_hp", int'(d_p2_hp[1]), 0);
        chk("lit_b_kill_winner", int'(d_winner[1]), 1);
        chk("lit_b_kill_busy", int'(d_busy[1]), 0);
        chk("lit_b_kill_p1_ready", int'(d_p1_ready[1]), 0);
        chk("lit_b_kill_p2_ready", int'(d_p2_ready[1]), 0);

        // P2 defend, P1 bite absorbed, P2 pass, P1 pounce full damage
        play(2, 3);
        play(1, 1);
        chk("lit_defend_p2_hp", int'(d_p2_hp[0]), 6);
        play(2, 0);
        play(1, 2);
        chk("lit_flag_spent_p2_hp", int'(d_p2_hp[0]), 4);
        chk("lit_flag_spent_p1_hp", int'(d_p1_hp[0]), 8);
        play(2, 0);

        // Both valid on P1's turn
        p2_valid = 1'b1;
        p2_move = 2'd2;
        chk("lit_both_p1_ready", int'(d_p1_ready[0]), 1);
        chk("lit_both_p2_ready", int'(d_p2_ready[0]), 0);
        play(1, 1);
        chk("lit_both_p2_hp", int'(d_p2_hp[0]), 3);
        chk("lit_both_p1_hp", int'(d_p1_hp[0]), 8);
        chk("lit_both_turn", int'(d_turn[0]), 1);
        play(2, 0);

        // P1 idles until the forced pass on the 15th cycle
        for (int c = 0; c < 14; c++) step();
        chk("lit_timeout_still_p1", int'(d_p1_ready[0]), 1);
        step();
        step();
        chk("lit_timeout_turn", int'(d_turn[0]), 1);
        chk("lit_timeout_p2_hp", int'(d_p2_hp[0]), 3);
        chk("lit_timeout_p1_hp", int'(d_p1_hp[0]), 8);

        // Start restarts B from OVER while A ignores it mid-battle
        start = 1'b1;
        step();
        start = 1'b0;
        chk("lit_b_restart_p1_hp", int'(d_p1_hp[1]), 2);
        chk("lit_b_restart_p2_hp", int'(d_p2_hp[1]), 2);
        chk("lit_b_restart_winner", int'(d_winner[1]), 0);
        chk("lit_a_ignores_start_p2_hp", int'(d_p2_hp[0]), 3);
        chk("lit_a_ignores_start_busy", int'(d_busy[0]), 1);

        // Reset during RESOLVE with enable low
        p2_valid = 1'b1;
        p2_move = 2'd1;
        step();
        p2_valid = 1'b0;
        ena = 1'b0;
        rst_n = 1'b0;
        step();
        chk("lit_rst_resolve_p1_hp", int'(d_p1_hp[0]), 8);
        chk("lit_rst_resolve_p2_hp", int'(d_p2_hp[0]), 8);
        chk("lit_rst_resolve_busy", int'(d_busy[0]), 0);
        rst_n = 1'b1;
        ena = 1'b1;
        step();

        // Randomized play
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            ena = ($urandom_range(0, 7) != 0);
            start = ($urandom_range(0, 11) == 0);
            p1_valid = ($urandom_range(0, 2) == 0);
            p1_move = 2'($urandom_range(0, 3));
            p2_valid = ($urandom_range(0, 2) == 0);
            p2_move = 2'($urandom_range(0, 3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
